// File: rtl/coh_bus_pkg.sv
// -----------------------------------------------------------------------------
// coh_bus_pkg
//   Shared definitions for the two-core snooping coherence bus arbiter:
//   FSM state encoding, bus operation codes and the default widths and
//   timeout used by the top level.
// -----------------------------------------------------------------------------
package coh_bus_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 15;
   localparam int L2_TIMEOUT_DEF = 255;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNOOP   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_L2_WAIT = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   typedef enum logic {
      BUS_RD  = 1'b0,
      BUS_RDX = 1'b1
   } bus_op_e;

   // Index of the core that is not the requester (two-core system).
   function automatic logic other_core(input logic idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
//   Two-way round-robin arbiter. Grant is combinational from the request
//   vector and the priority pointer; the pointer is registered and moves to
//   the other core whenever a grant is accepted.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset (pointer -> core 0)
//   req_i      request per core
//   accept_i   the current grant is taken this cycle
//   gnt_o      one-hot grant
//   gnt_idx_o  index of the granted core (valid when gnt_o != 0)
// -----------------------------------------------------------------------------
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o,
   output logic       gnt_idx_o
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt_o     = 2'b00;
      gnt_idx_o = 1'b0;
      if (ptr_q == 1'b0) begin
         if (req_i[0]) begin
            gnt_o     = 2'b01;
            gnt_idx_o = 1'b0;
         end else if (req_i[1]) begin
            gnt_o     = 2'b10;
            gnt_idx_o = 1'b1;
         end
      end else begin
         if (req_i[1]) begin
            gnt_o     = 2'b10;
            gnt_idx_o = 1'b1;
         end else if (req_i[0]) begin
            gnt_o     = 2'b01;
            gnt_idx_o = 1'b0;
         end
      end
   end

   // After a grant, the other core gets priority next time.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i && (req_i != 2'b00)) begin
         ptr_d = ~gnt_idx_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// -----------------------------------------------------------------------------
// coherence_bus_arbiter
//   Serialises BusRd / BusRdX requests from two cores onto a snooping bus.
//   One transaction at a time: arbitrate, broadcast a snoop, collect replies,
//   fill either from the other core (cache-to-cache) or from L2, then return
//   a one-cycle response to the requester. An L2 that does not answer within
//   L2_TIMEOUT cycles produces an error response with zero data.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_rd, req_rdx          per-core BusRd / BusRdX requests (level)
//   req_addr0, req_addr1     request line address of core 0 / core 1
//   grant                    one-hot, held for the whole transaction
//   snoop_valid/rdx/addr     one-cycle snoop broadcast
//   snoop_hit/supply/data    snoop replies, valid the cycle after snoop_valid
//   l2_busRd, l2_busRdX      one-cycle L2 request pulses
//   l2_addr                  L2 address, held until L2 responds
//   l2_supply, l2_rdata      L2 data return
//   resp_valid/data/shared/err  one-cycle response to the requester
// -----------------------------------------------------------------------------
module coherence_bus_arbiter
   import coh_bus_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int L2_TIMEOUT = L2_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_rd,
   input  logic [1:0]            req_rdx,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   output logic [1:0]            grant,
   output logic                  snoop_valid,
   output logic                  snoop_rdx,
   output logic [ADDR_WIDTH-1:0] snoop_addr,
   input  logic [1:0]            snoop_hit,
   input  logic [1:0]            snoop_supply,
   input  logic [DATA_WIDTH-1:0] snoop_data,
   output logic                  l2_busRd,
   output logic                  l2_busRdX,
   output logic [ADDR_WIDTH-1:0] l2_addr,
   input  logic                  l2_supply,
   input  logic [DATA_WIDTH-1:0] l2_rdata,
   output logic [1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_shared,
   output logic                  resp_err
);

   localparam int CNT_W = $clog2(L2_TIMEOUT + 1);

   // Control state
   state_e           state_q,  state_d;
   logic [1:0]       grant_q,  grant_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             shared_q, shared_d;
   logic             err_q,    err_d;

   // Transaction payload
   logic                  idx_q,  idx_d;
   bus_op_e               op_q,   op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic [1:0] req_any;
   logic [1:0] arb_gnt;
   logic       arb_idx;
   logic       oth;

   assign req_any = req_rd | req_rdx;
   assign oth     = other_core(idx_q);

   rr_arbiter_2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_any),
      .accept_i  (state_q == ST_IDLE),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx)
   );

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      shared_d = shared_q;
      err_d    = err_q;
      idx_d    = idx_q;
      op_d     = op_q;
      addr_d   = addr_q;
      data_d   = data_q;

      grant       = 2'b00;
      snoop_valid = 1'b0;
      snoop_rdx   = 1'b0;
      snoop_addr  = '0;
      l2_busRd    = 1'b0;
      l2_busRdX   = 1'b0;
      l2_addr     = '0;
      resp_valid  = 2'b00;
      resp_data   = '0;
      resp_shared = 1'b0;
      resp_err    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Grant is visible in the arbitration cycle itself.
            if (req_any != 2'b00) begin
               grant    = arb_gnt;
               grant_d  = arb_gnt;
               idx_d    = arb_idx;
               // rd+rdx together from one core is an RdX.
               op_d     = req_rdx[arb_idx] ? BUS_RDX : BUS_RD;
               addr_d   = arb_idx ? req_addr1 : req_addr0;
               shared_d = 1'b0;
               err_d    = 1'b0;
               cnt_d    = '0;
               state_d  = ST_SNOOP;
            end
         end

         ST_SNOOP: begin
            grant       = grant_q;
            snoop_valid = 1'b1;
            snoop_rdx   = (op_q == BUS_RDX);
            snoop_addr  = addr_q;
            state_d     = ST_COLLECT;
         end

         ST_COLLECT: begin
            // The requester's own reply bits are meaningless and ignored.
            grant    = grant_q;
            shared_d = snoop_hit[oth] && (op_q == BUS_RD);
            if (snoop_supply[oth]) begin
               data_d  = snoop_data;
               state_d = ST_RESP;
            end else begin
               l2_busRd  = (op_q == BUS_RD);
               l2_busRdX = (op_q == BUS_RDX);
               l2_addr   = addr_q;
               cnt_d     = CNT_W'(1);
               state_d   = ST_L2_WAIT;
            end
         end

         ST_L2_WAIT: begin
            grant   = grant_q;
            l2_addr = addr_q;
            if (l2_supply) begin
               data_d  = l2_rdata;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_W'(L2_TIMEOUT)) begin
               err_d   = 1'b1;
               data_d  = '0;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            grant       = grant_q;
            resp_valid  = grant_q;
            resp_data   = data_q;
            resp_shared = shared_q;
            resp_err    = err_q;
            grant_d     = 2'b00;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         grant_q  <= 2'b00;
         cnt_q    <= '0;
         shared_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         shared_q <= shared_d;
         err_q    <= err_d;
      end
   end

   // Payload is only observed through state-gated outputs, so no reset.
   always_ff @(posedge clk) begin
      idx_q  <= idx_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_coherence_bus_arbiter
//   Directed bench for coherence_bus_arbiter with default parameters.
// -----------------------------------------------------------------------------
module tb_coherence_bus_arbiter;

   localparam int DW = 32;
   localparam int AW = 15;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_rd, req_rdx;
   logic [AW-1:0] req_addr0, req_addr1;
   logic [1:0]    grant;
   logic          snoop_valid, snoop_rdx;
   logic [AW-1:0] snoop_addr;
   logic [1:0]    snoop_hit, snoop_supply;
   logic [DW-1:0] snoop_data;
   logic          l2_busRd, l2_busRdX;
   logic [AW-1:0] l2_addr;
   logic          l2_supply;
   logic [DW-1:0] l2_rdata;
   logic [1:0]    resp_valid;
   logic [DW-1:0] resp_data;
   logic          resp_shared, resp_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   coherence_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .L2_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_rd(req_rd), .req_rdx(req_rdx),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .grant(grant),
      .snoop_valid(snoop_valid), .snoop_rdx(snoop_rdx), .snoop_addr(snoop_addr),
      .snoop_hit(snoop_hit), .snoop_supply(snoop_supply), .snoop_data(snoop_data),
      .l2_busRd(l2_busRd), .l2_busRdX(l2_busRdX), .l2_addr(l2_addr),
      .l2_supply(l2_supply), .l2_rdata(l2_rdata),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_shared(resp_shared), .resp_err(resp_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_rd = 2'b00; req_rdx = 2'b00;
      req_addr0 = '0; req_addr1 = '0;
      snoop_hit = 2'b00; snoop_supply = 2'b00; snoop_data = '0;
      l2_supply = 1'b0; l2_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      step(); step();
      rst = 1'b0;
      l2_supply = 1'b1;          // stray L2 data while idle must be ignored
      l2_rdata  = 32'hFFFF_0000;
      #1;
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
      checks++; if (snoop_valid !== 1'b0 || l2_busRd !== 1'b0 || l2_busRdX !== 1'b0) begin
         failures++; $display("FAIL reset_strobes snoop_valid=%b l2_busRd=%b l2_busRdX=%b exp=0", snoop_valid, l2_busRd, l2_busRdX); end
      step();
      l2_supply = 1'b0;
      #1;
      checks++; if (resp_valid !== 2'b00 || resp_err !== 1'b0) begin
         failures++; $display("FAIL reset_resp resp_valid=%b resp_err=%b exp=00/0", resp_valid, resp_err); end
   endtask

   task automatic test_l2_fill();
      req_rd = 2'b01; req_addr0 = 15'h0123;
      #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL l2fill_grant got=%b exp=01", grant); end
      step(); #1;
      checks++; if (snoop_valid !== 1'b1 || snoop_rdx !== 1'b0 || snoop_addr !== 15'h0123) begin
         failures++; $display("FAIL l2fill_snoop valid=%b rdx=%b addr=%h exp=1/0/0123", snoop_valid, snoop_rdx, snoop_addr); end
      step(); #1;
      checks++; if (l2_busRd !== 1'b1 || l2_busRdX !== 1'b0 || l2_addr !== 15'h0123) begin
         failures++; $display("FAIL l2fill_req busRd=%b busRdX=%b addr=%h exp=1/0/0123", l2_busRd, l2_busRdX, l2_addr); end
      step(); #1;
      checks++; if (l2_busRd !== 1'b0 || l2_addr !== 15'h0123 || grant !== 2'b01) begin
         failures++; $display("FAIL l2fill_wait busRd=%b addr=%h grant=%b exp=0/0123/01", l2_busRd, l2_addr, grant); end
      step(); step(); step();
      l2_supply = 1'b1; l2_rdata = 32'hDEAD_BEEF;
      step();
      l2_supply = 1'b0; l2_rdata = '0;
      #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 32'hDEAD_BEEF || resp_shared !== 1'b0 || resp_err !== 1'b0) begin
         failures++; $display("FAIL l2fill_resp valid=%b data=%h shared=%b err=%b exp=01/deadbeef/0/0", resp_valid, resp_data, resp_shared, resp_err); end
      req_rd = 2'b00;
      step(); #1;
      checks++; if (grant !== 2'b00 || resp_valid !== 2'b00) begin
         failures++; $display("FAIL l2fill_done grant=%b resp_valid=%b exp=00/00", grant, resp_valid); end
   endtask

   task automatic test_snoop_supply();
      req_rdx = 2'b10; req_addr1 = 15'h7FFF;
      #1;
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL c2c_grant got=%b exp=10", grant); end
      step(); #1;
      checks++; if (snoop_valid !== 1'b1 || snoop_rdx !== 1'b1 || snoop_addr !== 15'h7FFF) begin
         failures++; $display("FAIL c2c_snoop valid=%b rdx=%b addr=%h exp=1/1/7fff", snoop_valid, snoop_rdx, snoop_addr); end
      step();
      snoop_supply = 2'b01; snoop_hit = 2'b01; snoop_data = 32'h1234_5678;
      #1;
      checks++; if (l2_busRd !== 1'b0 || l2_busRdX !== 1'b0) begin
         failures++; $display("FAIL c2c_no_l2 busRd=%b busRdX=%b exp=0/0", l2_busRd, l2_busRdX); end
      step();
      snoop_supply = 2'b00; snoop_hit = 2'b00; snoop_data = '0;
      #1;
      checks++; if (resp_valid !== 2'b10 || resp_data !== 32'h1234_5678 || resp_shared !== 1'b0) begin
         failures++; $display("FAIL c2c_resp valid=%b data=%h shared=%b exp=10/12345678/0", resp_valid, resp_data, resp_shared); end
      req_rdx = 2'b00;
      step();
   endtask

   // Walks SNOOP -> COLLECT -> RESP with the given core supplying data.
   task automatic supplied_txn(input logic [1:0] sup, input logic [DW-1:0] d);
      step(); step();
      snoop_supply = sup; snoop_data = d;
      step();
      snoop_supply = 2'b00; snoop_data = '0;
   endtask

   task automatic test_round_robin();
      rst = 1'b1; clear_inputs();
      step(); step();
      rst = 1'b0;
      req_rd = 2'b11; req_addr0 = 15'h0010; req_addr1 = 15'h0020;
      #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rr_first grant=%b exp=01", grant); end
      supplied_txn(2'b10, 32'h1111_1111);
      #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 32'h1111_1111) begin
         failures++; $display("FAIL rr_first_resp valid=%b data=%h exp=01/11111111", resp_valid, resp_data); end
      req_rd = 2'b10;
      step(); #1;
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rr_second grant=%b exp=10", grant); end
      step(); #1;
      checks++; if (snoop_addr !== 15'h0020) begin failures++; $display("FAIL rr_second_addr got=%h exp=0020", snoop_addr); end
      step();
      snoop_supply = 2'b01; snoop_data = 32'h2222_2222;
      step();
      snoop_supply = 2'b00; snoop_data = '0;
      #1;
      checks++; if (resp_valid !== 2'b10 || resp_data !== 32'h2222_2222) begin
         failures++; $display("FAIL rr_second_resp valid=%b data=%h exp=10/22222222", resp_valid, resp_data); end
      req_rd = 2'b11;
      step(); #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rr_third grant=%b exp=01", grant); end
      supplied_txn(2'b10, 32'h3333_3333);
      req_rd = 2'b00;
      step();
   endtask

   task automatic test_shared();
      req_rd = 2'b01; req_addr0 = 15'h0055;
      step(); step();
      snoop_hit = 2'b11; snoop_supply = 2'b01;  // own supply bit must be ignored
      #1;
      checks++; if (l2_busRd !== 1'b1) begin failures++; $display("FAIL shared_own_supply_ignored busRd=%b exp=1", l2_busRd); end
      step();
      snoop_hit = 2'b00; snoop_supply = 2'b00;
      l2_supply = 1'b1; l2_rdata = 32'hCAFE_F00D;
      step();
      l2_supply = 1'b0; l2_rdata = '0;
      #1;
      checks++; if (resp_valid !== 2'b01 || resp_shared !== 1'b1 || resp_data !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL shared_rd valid=%b shared=%b data=%h exp=01/1/cafef00d", resp_valid, resp_shared, resp_data); end
      req_rd = 2'b00;
      step();
      // rd and rdx together from core 0 behaves as RdX
      req_rd = 2'b01; req_rdx = 2'b01;
      step(); #1;
      checks++; if (snoop_rdx !== 1'b1) begin failures++; $display("FAIL shared_rdx_snoop rdx=%b exp=1", snoop_rdx); end
      step();
      snoop_hit = 2'b10;
      #1;
      checks++; if (l2_busRdX !== 1'b1 || l2_busRd !== 1'b0) begin
         failures++; $display("FAIL shared_rdx_l2 busRdX=%b busRd=%b exp=1/0", l2_busRdX, l2_busRd); end
      step();
      snoop_hit = 2'b00;
      l2_supply = 1'b1; l2_rdata = 32'h0F0F_0F0F;
      step();
      l2_supply = 1'b0; l2_rdata = '0;
      #1;
      checks++; if (resp_valid !== 2'b01 || resp_shared !== 1'b0 || resp_data !== 32'h0F0F_0F0F) begin
         failures++; $display("FAIL shared_rdx_resp valid=%b shared=%b data=%h exp=01/0/0f0f0f0f", resp_valid, resp_shared, resp_data); end
      req_rd = 2'b00; req_rdx = 2'b00;
      step();
   endtask

   task automatic test_timeout();
      int k;
      req_rd = 2'b01; req_addr0 = 15'h0ABC;
      step(); step();
      #1;
      checks++; if (l2_busRd !== 1'b1) begin failures++; $display("FAIL timeout_req busRd=%b exp=1", l2_busRd); end
      step();                         // first L2_WAIT cycle
      k = 0;
      while (resp_valid === 2'b00 && k < TO + 20) begin
         step();
         k++;
      end
      checks++; if (k !== TO) begin failures++; $display("FAIL timeout_latency cycles=%0d exp=%0d", k, TO); end
      checks++; if (resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_data !== 32'h0) begin
         failures++; $display("FAIL timeout_resp valid=%b err=%b data=%h exp=01/1/0", resp_valid, resp_err, resp_data); end
      req_rd = 2'b00;
      step(); #1;
      checks++; if (resp_err !== 1'b0 || grant !== 2'b00) begin
         failures++; $display("FAIL timeout_after err=%b grant=%b exp=0/00", resp_err, grant); end
   endtask

   task automatic test_reset_midflight();
      int seen;
      req_rd = 2'b01; req_addr0 = 15'h0042;
      step(); step(); step(); step();  // SNOOP, COLLECT, L2_WAIT x2
      rst = 1'b1; req_rd = 2'b00;
      step(); #1;
      checks++; if (grant !== 2'b00 || snoop_valid !== 1'b0 || l2_addr !== '0) begin
         failures++; $display("FAIL midrst_idle grant=%b snoop_valid=%b l2_addr=%h exp=00/0/0", grant, snoop_valid, l2_addr); end
      rst = 1'b0;
      l2_supply = 1'b1; l2_rdata = 32'hBAD0_BAD0;
      step();
      l2_supply = 1'b0; l2_rdata = '0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (resp_valid !== 2'b00) seen++;
         step();
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_resp resp_cycles=%0d exp=0", seen); end
      // pointer was left at core 1; reset must return it to core 0
      req_rd = 2'b11;
      #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL midrst_ptr grant=%b exp=01", grant); end
      supplied_txn(2'b10, 32'h4444_4444);
      req_rd = 2'b00;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_l2_fill();
      test_snoop_supply();
      test_round_robin();
      test_shared();
      test_timeout();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coherence_bus_arbiter.md
COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width.
REQ-002 Parameter ADDR_WIDTH, default 15: line address width.
REQ-003 Parameter L2_TIMEOUT, default 255: max cycles to wait for an L2 supply.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_rd  in  2  per-core BusRd request (bit i = core i).
REQ-007 req_rdx  in  2  per-core BusRdX request.
REQ-008 req_addr0, req_addr1  in  ADDR_WIDTH each  request address of core 0 / core 1.
REQ-009 grant  out  2  one-hot, high for the whole transaction of the granted core.
REQ-010 snoop_valid  out  1  one-cycle snoop broadcast strobe.
REQ-011 snoop_rdx  out  1  snoop is BusRdX (invalidate), else BusRd.
REQ-012 snoop_addr  out  ADDR_WIDTH  snooped address.
REQ-013 snoop_hit  in  2  per-core "line held" reply, valid the cycle after snoop_valid.
REQ-014 snoop_supply  in  2  per-core "I supply data" reply (M/O owner), same timing.
REQ-015 snoop_data  in  DATA_WIDTH  cache-to-cache data, valid with snoop_supply.
REQ-016 l2_busRd, l2_busRdX  out  1 each  one-cycle request pulses to L2.
REQ-017 l2_addr  out  ADDR_WIDTH  L2 request address, held until L2 responds.
REQ-018 l2_supply  in  1  L2 data valid strobe.
REQ-019 l2_rdata  in  DATA_WIDTH  L2 data, valid with l2_supply.
REQ-020 resp_valid  out  2  one-hot, one-cycle response to the requester.
REQ-021 resp_data  out  DATA_WIDTH  fill data, valid with resp_valid.
REQ-022 resp_shared  out  1  another core holds the line (requester fills S, else E/M).
REQ-023 resp_err  out  1  one-cycle pulse with resp_valid when L2 timed out; resp_data = 0.

Function
REQ-024 FSM states: IDLE, SNOOP, COLLECT, L2_WAIT, RESP.
REQ-025 IDLE: if any req_rd|req_rdx, latch winner, type, address; assert grant; go SNOOP next cycle.
REQ-026 Arbitration: round-robin; pointer starts at core 0; after a grant it points to the other core.
REQ-027 Same core asserting req_rd and req_rdx simultaneously: treated as BusRdX.
REQ-028 SNOOP (1 cycle): snoop_valid=1, snoop_rdx, snoop_addr driven; go COLLECT.
REQ-029 COLLECT: replies from the granted core's own bit are ignored; resp_shared latched = other core's snoop_hit AND NOT rdx.
REQ-030 COLLECT: other core's snoop_supply=1 -> latch snoop_data, go RESP (no L2 request).
REQ-031 COLLECT: else pulse l2_busRd (BusRd) or l2_busRdX (BusRdX) one cycle, go L2_WAIT.
REQ-032 L2_WAIT: l2_supply -> latch l2_rdata, go RESP; l2_supply outside L2_WAIT is ignored.
REQ-033 L2_WAIT: cycle counter from 1; reaching L2_TIMEOUT without l2_supply -> set error, go RESP.
REQ-034 RESP (1 cycle): resp_valid = grant, resp_data, resp_shared, resp_err driven; then grant drops, IDLE.
REQ-035 Requests are level-sensitive; requester deasserts after resp_valid; new arbitration starts in IDLE the cycle after RESP.
REQ-036 Latency: snoop-supplied fill resp_valid 3 cycles after grant; L2 fill 1 cycle after l2_supply.
REQ-037 Requests arriving mid-transaction wait; exactly one transaction outstanding.

Reset
REQ-038 rst forces IDLE, RR pointer to core 0, counter 0, all outputs 0, regardless of state; in-flight transaction is dropped without response.

Structure
REQ-039 State encodings, bus-op codes (BUS_RD, BUS_RDX), default widths in shared package coh_bus_pkg.
REQ-040 One sub-module: rr_arbiter_2 (2-way round-robin, combinational grant, registered pointer).

Verification
REQ-041 Core0 req_rd addr 0x0123, no snoop replies, l2_supply with 0xDEADBEEF 4 cycles after l2_busRd -> resp_valid=01, data 0xDEADBEEF, shared=0.
REQ-042 Core1 req_rdx addr 0x7FFF, core0 snoop_supply=1 data 0x12345678 -> resp_valid=10, data 0x12345678, no l2 pulse, snoop_rdx=1.
REQ-043 Both cores req_rd same cycle after reset -> core0 granted first, core1 next; repeat -> core0 again after core1.
REQ-044 Core0 req_rd, core1 snoop_hit=1 supply=0 -> L2 fill, resp_shared=1; same with req_rdx -> resp_shared=0.
REQ-045 L2 never supplies -> resp_valid with resp_err=1, data 0, exactly L2_TIMEOUT cycles into L2_WAIT.
REQ-046 rst asserted in L2_WAIT -> next cycle grant=00, IDLE; later l2_supply produces no resp_valid.
